// File: rtl/el2_iccm_access_sequencer.sv
// ICCM access sequencer: turns READ / WRITE / SWEEP commands into ICCM port
// strobes and returns read data, write acks or a sweep XOR checksum.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_*             command channel (valid/ready), op 0=RD 1=WR 2=SWEEP 3=RD
//   rsp_*             response channel (valid/ready): data, raw ecc, beat count
//   iccm_*            ICCM initiator port (strobes, address, size, write data,
//                     read data returned RD_LATENCY cycles after iccm_rden)
module el2_iccm_access_sequencer #(
  parameter int ICCM_BITS  = 16,
  parameter int RD_LATENCY = 1,
  parameter int LEN_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ICCM_BITS-2:0] cmd_addr,
  input  logic [2:0]           cmd_size,
  input  logic [77:0]          cmd_wdata,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_data,
  output logic [77:0]          rsp_ecc,
  output logic [LEN_W-1:0]     rsp_count,
  output logic                 iccm_wren,
  output logic                 iccm_rden,
  output logic [ICCM_BITS-2:0] iccm_rw_addr,
  output logic [2:0]           iccm_wr_size,
  output logic [77:0]          iccm_wr_data,
  output logic                 iccm_buf_correct_ecc,
  output logic                 iccm_correction_state,
  input  logic [63:0]          iccm_rd_data,
  input  logic [77:0]          iccm_rd_data_ecc
);

  localparam int AW = ICCM_BITS - 1;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    SWEEP,
    SWEEP_DRAIN,
    RSP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      iss_q;
  logic [LEN_W-1:0]      beats_q;
  logic [63:0]           csum_q;
  logic [RD_LATENCY-1:0] pipe_q;

  logic accept;
  logic ret;
  logic last_iss;
  logic last_ret;
  logic in_sweep;

  assign iccm_buf_correct_ecc  = 1'b0;
  assign iccm_correction_state = 1'b0;

  assign accept   = (state == IDLE) && cmd_valid && cmd_ready;
  // Oldest pipe stage marks the cycle the ICCM read data is valid.
  assign ret      = pipe_q[RD_LATENCY-1];
  assign last_iss = (iss_q == len_q - ONE);
  assign last_ret = ret && (beats_q + ONE == len_q);
  assign in_sweep = (state == SWEEP) || (state == SWEEP_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            2'd1:    state_nxt = WR;
            2'd2:    state_nxt = (cmd_len == '0) ? RSP : SWEEP;
            default: state_nxt = RD;
          endcase
        end
      end
      WR:          state_nxt = RSP;
      RD:          state_nxt = RD_WAIT;
      RD_WAIT:     if (ret) state_nxt = RSP;
      SWEEP:       if (last_iss) state_nxt = SWEEP_DRAIN;
      SWEEP_DRAIN: if (last_ret) state_nxt = RSP;
      RSP:         if (rsp_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_ecc      <= '0;
      rsp_count    <= '0;
      iccm_wren    <= 1'b0;
      iccm_rden    <= 1'b0;
      iccm_rw_addr <= '0;
      iccm_wr_size <= '0;
      iccm_wr_data <= '0;
      len_q        <= '0;
      iss_q        <= '0;
      beats_q      <= '0;
      csum_q       <= '0;
      pipe_q       <= '0;
    end else begin
      // Ready only after a full IDLE cycle, giving one dead cycle after RSP.
      cmd_ready <= (state == IDLE) && (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RSP);
      iccm_wren <= (state_nxt == WR);
      iccm_rden <= (state_nxt == RD) || (state_nxt == SWEEP);

      pipe_q[0] <= iccm_rden;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end

      if (in_sweep && ret) begin
        csum_q  <= csum_q ^ iccm_rd_data;
        beats_q <= beats_q + ONE;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            len_q   <= cmd_len;
            iss_q   <= '0;
            beats_q <= '0;
            csum_q  <= '0;
            if (state_nxt == WR) begin
              iccm_rw_addr <= cmd_addr;
              iccm_wr_size <= cmd_size;
              iccm_wr_data <= cmd_wdata;
            end else if (state_nxt == RD) begin
              iccm_rw_addr <= cmd_addr;
              iccm_wr_size <= cmd_size;
            end else if (state_nxt == SWEEP) begin
              iccm_rw_addr <= cmd_addr;
              iccm_wr_size <= 3'b011;
            end else begin
              rsp_data  <= '0;
              rsp_ecc   <= '0;
              rsp_count <= '0;
            end
          end
        end
        WR: begin
          rsp_data  <= '0;
          rsp_ecc   <= '0;
          rsp_count <= ONE;
        end
        RD_WAIT: begin
          if (ret) begin
            rsp_data  <= iccm_rd_data;
            rsp_ecc   <= iccm_rd_data_ecc;
            rsp_count <= ONE;
          end
        end
        SWEEP: begin
          iss_q <= iss_q + ONE;
          // One 64-bit word per beat; wraps at the top of the ICCM.
          if (!last_iss) begin
            iccm_rw_addr <= iccm_rw_addr + AW'(4);
          end
        end
        SWEEP_DRAIN: begin
          if (last_ret) begin
            rsp_data  <= csum_q ^ iccm_rd_data;
            rsp_ecc   <= '0;
            rsp_count <= len_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_el2_iccm_access_sequencer.sv
// Bench for el2_iccm_access_sequencer: vector table, hand-written corner
// sequences and random commands against a word-level reference model.
module tb_el2_iccm_access_sequencer;

  localparam int IB  = 16;
  localparam int LAT = 2;
  localparam int LW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [14:0]   cmd_addr = '0;
  logic [2:0]    cmd_size = '0;
  logic [77:0]   cmd_wdata = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [63:0]   rsp_data;
  logic [77:0]   rsp_ecc;
  logic [LW-1:0] rsp_count;
  logic          iccm_wren;
  logic          iccm_rden;
  logic [14:0]   iccm_rw_addr;
  logic [2:0]    iccm_wr_size;
  logic [77:0]   iccm_wr_data;
  logic          iccm_buf_correct_ecc;
  logic          iccm_correction_state;
  logic [63:0]   iccm_rd_data;
  logic [77:0]   iccm_rd_data_ecc;

  el2_iccm_access_sequencer #(
    .ICCM_BITS(IB),
    .RD_LATENCY(LAT),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_size(cmd_size),
    .cmd_wdata(cmd_wdata),
    .cmd_len(cmd_len),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_ecc(rsp_ecc),
    .rsp_count(rsp_count),
    .iccm_wren(iccm_wren),
    .iccm_rden(iccm_rden),
    .iccm_rw_addr(iccm_rw_addr),
    .iccm_wr_size(iccm_wr_size),
    .iccm_wr_data(iccm_wr_data),
    .iccm_buf_correct_ecc(iccm_buf_correct_ecc),
    .iccm_correction_state(iccm_correction_state),
    .iccm_rd_data(iccm_rd_data),
    .iccm_rd_data_ecc(iccm_rd_data_ecc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ICCM memory: 8192 x 64-bit words, stored with ECC bits.
  logic [77:0] mem [0:8191];
  logic [77:0] ref_mem [0:8191];
  logic [77:0] st_d [LAT];
  logic [LAT-1:0] st_v = '0;
  logic [63:0] junk = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (iccm_wren) mem[iccm_rw_addr[14:2]] <= iccm_wr_data;
    st_v[0] <= iccm_rden;
    st_d[0] <= mem[iccm_rw_addr[14:2]];
    for (int i = 1; i < LAT; i++) begin
      st_v[i] <= st_v[i-1];
      st_d[i] <= st_d[i-1];
    end
  end

  always @(negedge clk) junk <= {$urandom, $urandom};

  // Outside the valid return cycle the bus carries random junk.
  assign iccm_rd_data     = st_v[LAT-1] ? st_d[LAT-1][63:0] : junk;
  assign iccm_rd_data_ecc = st_v[LAT-1] ? st_d[LAT-1] : {junk[13:0], junk};

  logic [1:0]  s_kind [$];
  logic [14:0] s_addr [$];
  logic [2:0]  s_size [$];
  logic [77:0] s_wd [$];
  int          s_cyc [$];

  always @(negedge clk) begin
    if (iccm_wren || iccm_rden) begin
      checks++;
      if (iccm_wren && iccm_rden) begin
        errors++;
        $display("FAIL strobe_overlap wren=%0b rden=%0b need one-hot",
                 iccm_wren, iccm_rden);
      end
      s_kind.push_back({iccm_rden, iccm_wren});
      s_addr.push_back(iccm_rw_addr);
      s_size.push_back(iccm_wr_size);
      s_wd.push_back(iccm_wr_data);
      s_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic clear_log();
    s_kind.delete();
    s_addr.delete();
    s_size.delete();
    s_wd.delete();
    s_cyc.delete();
  endtask

  // Reference model: word-level view of the ICCM.
  task automatic model(input logic [1:0] op, input logic [14:0] a,
                       input logic [77:0] wd, input logic [15:0] len,
                       output logic [63:0] d, output logic [77:0] e,
                       output logic [15:0] c);
    logic [14:0] wa;
    d = '0;
    e = '0;
    c = 16'd1;
    if (op == 2'd1) begin
      ref_mem[a[14:2]] = wd;
    end else if (op == 2'd2) begin
      for (int i = 0; i < int'(len); i++) begin
        wa = a + 15'(4 * i);
        d = d ^ ref_mem[wa[14:2]][63:0];
      end
      c = len;
    end else begin
      d = ref_mem[a[14:2]][63:0];
      e = ref_mem[a[14:2]];
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [14:0] a,
                        input logic [2:0] sz, input logic [77:0] wd,
                        input logic [15:0] len, input int bp,
                        output logic [63:0] d, output logic [77:0] e,
                        output logic [15:0] c, output int vcyc);
    int n;
    int ns;
    bit moved;
    d = '0;
    e = '0;
    c = '1;
    vcyc = 0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      timeout("cmd_ready");
      return;
    end
    clear_log();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_size  = sz;
    cmd_wdata = wd;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      timeout("rsp_valid");
      return;
    end
    vcyc = cyc;
    d = rsp_data;
    e = rsp_ecc;
    c = rsp_count;
    moved = 1'b0;
    for (int k = 0; k < bp; k++) begin
      ns = s_kind.size();
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_no_strobe", s_kind.size(), ns);
      if (rsp_data !== d || rsp_ecc !== e || rsp_count !== c) moved = 1'b1;
    end
    if (bp > 0) chk("bp_payload_stable", moved, 0);
    d = rsp_data;
    e = rsp_ecc;
    c = rsp_count;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("idle_gap", cmd_ready, 0);
  endtask

  task automatic run(input string nm, input logic [1:0] op,
                     input logic [14:0] a, input logic [2:0] sz,
                     input logic [77:0] wd, input logic [15:0] len,
                     input int bp, input logic [63:0] xd,
                     input logic [77:0] xe, input logic [15:0] xc);
    logic [63:0] d;
    logic [77:0] e;
    logic [15:0] c;
    int vcyc;
    int n;
    logic [1:0] k;
    logic [14:0] ea;
    logic [2:0] es;
    logic [77:0] ew;
    do_cmd(op, a, sz, wd, len, bp, d, e, c, vcyc);
    chk({nm, "_data"}, d, xd);
    chk({nm, "_ecc"}, e, xe);
    chk({nm, "_count"}, c, xc);
    n = (op == 2'd2) ? int'(len) : 1;
    chk({nm, "_nstrobe"}, s_kind.size(), n);
    k  = (op == 2'd1) ? 2'b01 : 2'b10;
    es = (op == 2'd2) ? 3'b011 : sz;
    ew = (op == 2'd1) ? wd : 78'h0;
    for (int i = 0; i < n && i < s_kind.size(); i++) begin
      ea = a + 15'(4 * i);
      chk({nm, "_beat"},
          {s_kind[i], s_addr[i], s_size[i],
           (s_kind[i] == 2'b01) ? s_wd[i] : 78'h0},
          {k, ea, es, ew});
      if (i > 0) chk({nm, "_b2b"}, s_cyc[i] - s_cyc[0], i);
    end
    if (n > 0 && s_kind.size() > 0)
      chk({nm, "_latency"}, vcyc - s_cyc[s_kind.size()-1],
          (op == 2'd1) ? 1 : LAT + 1);
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [14:0] addr;
    logic [2:0]  size;
    logic [77:0] wdata;
    logic [15:0] len;
    int          bp;
    logic [63:0] xd;
    logic [77:0] xe;
    logic [15:0] xc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [95:0] r;
    logic [63:0] xd;
    logic [77:0] xe;
    logic [15:0] xc;
    logic [1:0]  op;
    logic [14:0] a;
    logic [15:0] len;
    int n;

    for (int w = 0; w < 8192; w++) begin
      r = {$urandom, $urandom, $urandom};
      mem[w] = r[77:0];
      ref_mem[w] = r[77:0];
    end
    for (int w = 0; w < 4; w++) begin
      mem[w] = 78'(w + 1);
      ref_mem[w] = 78'(w + 1);
    end
    mem[8191] = 78'hA5;
    ref_mem[8191] = 78'hA5;

    tbl[0] = '{"wr", 2'd1, 15'h0010, 3'd3, 78'h3A_5A5A5A5A_12345678,
               16'd0, 0, 64'h0, 78'h0, 16'd1};
    tbl[1] = '{"rd", 2'd0, 15'h0010, 3'd3, 78'h0, 16'd0, 0,
               64'h5A5A5A5A_12345678, 78'h3A_5A5A5A5A_12345678, 16'd1};
    tbl[2] = '{"sweep4", 2'd2, 15'h0000, 3'd0, 78'h0, 16'd4, 0,
               64'h4, 78'h0, 16'd4};
    tbl[3] = '{"sweep_wrap", 2'd2, 15'h7FFC, 3'd0, 78'h0, 16'd2, 0,
               64'hA4, 78'h0, 16'd2};
    tbl[4] = '{"sweep0", 2'd2, 15'h0000, 3'd0, 78'h0, 16'd0, 0,
               64'h0, 78'h0, 16'd0};
    tbl[5] = '{"sweep_bp", 2'd2, 15'h0000, 3'd0, 78'h0, 16'd4, 5,
               64'h4, 78'h0, 16'd4};
    tbl[6] = '{"rd_op3", 2'd3, 15'h0010, 3'd2, 78'h0, 16'd0, 0,
               64'h5A5A5A5A_12345678, 78'h3A_5A5A5A5A_12345678, 16'd1};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_payload", {rsp_data, rsp_count}, 0);
    chk("rst_strobes", {iccm_wren, iccm_rden}, 0);
    chk("rst_port", {iccm_rw_addr, iccm_wr_size, iccm_wr_data}, 0);
    chk("rst_tied", {iccm_buf_correct_ecc, iccm_correction_state}, 0);
    rst = 1'b0;
    chk("rst_release_ready", cmd_ready, 0);
    @(negedge clk);
    chk("first_ready", cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].op == 2'd1) ref_mem[tbl[i].addr[14:2]] = tbl[i].wdata;
      run(tbl[i].nm, tbl[i].op, tbl[i].addr, tbl[i].size, tbl[i].wdata,
          tbl[i].len, tbl[i].bp, tbl[i].xd, tbl[i].xe, tbl[i].xc);
    end

    // One dead cycle, then ready again.
    @(negedge clk);
    chk("ready_after_gap", cmd_ready, 1);

    // Reset in the middle of a long sweep.
    clear_log();
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_addr  = 15'h0;
    cmd_len   = 16'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (s_kind.size() < 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (s_kind.size() < 3) timeout("sweep_beat3");
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", {iccm_wren, iccm_rden}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", cmd_ready, 1);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_valid, 0);
    model(2'd2, 15'h0, 78'h0, 16'd4, xd, xe, xc);
    run("fresh_sweep", 2'd2, 15'h0, 3'd0, 78'h0, 16'd4, 0, xd, xe, xc);

    for (int t = 0; t < 40; t++) begin
      op  = 2'($urandom_range(0, 3));
      a   = 15'($urandom);
      len = 16'($urandom_range(0, 12));
      r   = {$urandom, $urandom, $urandom};
      // Bias toward a small window so reads hit earlier writes.
      if ($urandom_range(0, 1) == 1) a = {9'h0, a[5:0]};
      model(op, a, r[77:0], len, xd, xe, xc);
      run("rand", op, a, 3'($urandom), r[77:0], len,
          $urandom_range(0, 3), xd, xe, xc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/el2_iccm_access_sequencer.md
Name: el2_iccm_access_sequencer

Overview:
Initiator-side driver for the ICCM access port (iccm_wren/iccm_rden/iccm_rw_addr/iccm_wr_size/iccm_wr_data and returned iccm_rd_data/iccm_rd_data_ecc). It accepts single read, single write and multi-word sweep commands on a valid/ready command channel. It sequences them onto the ICCM port, honouring the fixed read latency, and returns results on a valid/ready response channel. It is used in block-level benches and for debug/scrub access, sitting in front of the ICCM memory wrapper.

Parameters:
ICCM_BITS, 16, ICCM byte-address width; port address is [ICCM_BITS-1:1]
RD_LATENCY, 1, cycles from iccm_rden high to valid iccm_rd_data/iccm_rd_data_ecc (legal 1..4)
LEN_W, 16, width of sweep length field

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when valid&&ready
cmd_op  input  2  0=READ, 1=WRITE, 2=SWEEP, 3=reserved (treated as READ)
cmd_addr  input  ICCM_BITS-1  start address [ICCM_BITS-1:1]
cmd_size  input  3  access size for READ/WRITE
cmd_wdata  input  78  write data incl. ECC (two 39-bit words)
cmd_len  input  LEN_W  SWEEP beat count (64-bit words)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when valid&&ready
rsp_data  output  64  read data / sweep XOR checksum / 0 for write
rsp_ecc  output  78  raw iccm_rd_data_ecc of READ; 0 otherwise
rsp_count  output  LEN_W  beats completed (1 for READ/WRITE)
iccm_wren  output  1  ICCM write strobe
iccm_rden  output  1  ICCM read strobe
iccm_rw_addr  output  ICCM_BITS-1  ICCM address
iccm_wr_size  output  3  ICCM access size
iccm_wr_data  output  78  ICCM write data
iccm_buf_correct_ecc  output  1  tied 0
iccm_correction_state  output  1  tied 0
iccm_rd_data  input  64  ICCM read data
iccm_rd_data_ecc  input  78  ICCM read data with ECC

Behaviour:
- Clock clk; reset rst is synchronous and active-high. Reset is sampled on clk edge only.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_ecc=0, rsp_count=0, iccm_wren=0, iccm_rden=0, iccm_rw_addr=0, iccm_wr_size=0, iccm_wr_data=0. State=IDLE.
- States: IDLE, WR, RD, RD_WAIT, SWEEP, SWEEP_DRAIN, RSP.
- IDLE: cmd_ready=1 (registered; first 1 is the cycle after rst deasserts). On accept, latch the command, drop cmd_ready, and transition on op.
- WR: iccm_wren=1 for exactly one cycle with the latched addr/size/wdata. Next state RSP with rsp_data=0, rsp_ecc=0, rsp_count=1.
- RD: iccm_rden=1 for exactly one cycle with latched addr/size. RD_WAIT waits RD_LATENCY-1 cycles. Data is sampled RD_LATENCY cycles after the rden cycle into rsp_data/rsp_ecc, with rsp_count=1. Then RSP.
- SWEEP: issues iccm_rden=1 on consecutive cycles for cmd_len beats, with iccm_wr_size=3'b011. Address starts at cmd_addr and increments by 4 (8 bytes) per beat, wrapping modulo 2^(ICCM_BITS-1).
- Read returns are tracked by a RD_LATENCY-deep valid shift pipe. Each returning beat XORs iccm_rd_data into the checksum and increments the count.
- After the last rden, SWEEP_DRAIN waits for the pipe to empty, then RSP with rsp_data=checksum, rsp_count=cmd_len.
- cmd_len=0: no ICCM access; go directly to RSP with rsp_data=0, rsp_count=0.
- iccm_wren and iccm_rden are never high in the same cycle. iccm_rw_addr/size/wr_data hold their last driven values when the strobes are low.
- RSP: rsp_valid held with stable payload until rsp_ready. On handshake, rsp_valid=0 next cycle and state goes to IDLE. cmd_ready=1 the cycle after that, so there is a minimum of 1 idle cycle between commands.
- Reset mid-operation: the next edge forces IDLE and reset values. In-flight read returns are discarded, and a partial checksum is never reported.
- Checksum and count registers clear on every command accept.

Test Plan:
- Write then read: WRITE addr=0x0010, size=3, wdata=78'h3A_5A5A5A5A_12345678 -> one-cycle iccm_wren with those values; rsp_data=0, rsp_count=1. READ same addr -> one-cycle iccm_rden; rsp_data=64'h..., rsp_ecc equals the memory's iccm_rd_data_ecc.
- Latency: RD_LATENCY=2 build, READ -> data sampled exactly 2 cycles after rden; wrong-cycle bus values are not captured.
- Sweep: memory preloaded with word i = i+1 at addr 0x0000, len=4 -> 4 back-to-back rden at addresses 0x0000, 0x0004, 0x0008, 0x000C; rsp_data=1^2^3^4=4, rsp_count=4.
- Wrap and zero length: SWEEP addr=0x7FFC, len=2 (ICCM_BITS=16) -> addresses 0x7FFC then 0x0000. SWEEP len=0 -> no strobes; rsp_count=0, rsp_data=0.
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid and payload stable, cmd_ready=0, no ICCM strobes.
- Reset mid-sweep: assert rst at beat 3 of a len=8 sweep -> strobes low and rsp_valid=0 after the edge; cmd_ready=1 the cycle after rst deasserts; the next sweep returns the correct fresh checksum.
